morse_symbol_capture: RTL and testbench
=======================================

MORSE_SYMBOL_CAPTURE -- requirements
Module: morse_symbol_capture

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000; consecutive stable synchronized samples required to accept a key level change.
REQ-002 SHALL have parameter DOT_MAX_CYCLES, default 10000000; a press lasting this many cycles or fewer is a dot, and a longer press is a dash.
REQ-003 SHALL have parameter GAP_CYCLES, default 20000000; release length that terminates a letter.
REQ-004 SHALL have parameter WORD_GAP_CYCLES, default 50000000; release length that produces a word space, used only with MORSE_WORD_GAP_EN.
REQ-005 SHALL have port clock, input, 1; the single clock, with all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1; synchronous, active-high reset.
REQ-007 SHALL have port morse, input, 1; raw asynchronous key, 1 = pressed.
REQ-008 SHALL have port code, output, 5; elements of the letter, LSB = first element, 1 = dash, 0 = dot.
REQ-009 SHALL have port code_len, output, 3; number of elements, 0..5, where 0 = word space.
REQ-010 SHALL have port code_err, output, 1; the letter exceeded 5 elements.
REQ-011 SHALL have port code_valid, output, 1; the output buffer holds a symbol.
REQ-012 SHALL have port code_ready, input, 1; the consumer (processor) accepts the symbol.
REQ-013 SHALL have port overrun, output, 1; sticky flag set when a symbol was dropped.
REQ-014 SHALL have port key_db, output, 1; debounced key level.

Function
REQ-015 SHALL pass morse through a 2-flop synchronizer before any other use.
REQ-016 SHALL toggle key_db on the edge at which the DEBOUNCE_CYCLES-th consecutive synchronized sample differing from key_db is seen; any sample equal to key_db SHALL clear the debounce counter.
REQ-017 SHALL implement states IDLE, PRESS and GAP; transitions are taken on key_db edges, meaning key_db differs from its value on the previous cycle.
REQ-018 SHALL, in IDLE or GAP on a key_db rise, go to PRESS and load the duration counter with 1.
REQ-019 SHALL, in PRESS, increment the duration counter each cycle; the counter is 26 bits and saturates at all-ones.
REQ-020 SHALL, in PRESS on a key_db fall, classify the element (count ≤ DOT_MAX_CYCLES gives a dot, otherwise a dash), then go to GAP and load the gap counter with 1.
REQ-021 SHALL store an element as follows:
- when the assembly length is below 5, write the element to bit[len] and increment len;
- when the assembly length is already 5, discard the element and set the assembly error bit.
REQ-022 SHALL, in GAP, increment the saturating gap counter each cycle; when it equals GAP_CYCLES it emits the assembled letter {code, len, err}, clears the assembly and goes to IDLE.
REQ-023 SHALL, on a key_db rise in GAP before GAP_CYCLES is reached, continue the same letter and emit nothing.
REQ-024 SHALL handle emission with a one-entry buffer:
- when the buffer is empty, the symbol is loaded and code_valid is 1 on the next cycle;
- when the buffer is full and not accepted that cycle, the symbol is dropped and overrun is set.
REQ-025 SHALL accept a symbol when code_valid and code_ready are both 1 at a rising edge; code_valid then goes to 0 on the next cycle unless a new symbol loads that same edge.
REQ-026 SHALL, when accept and emit occur in the same cycle, load the new symbol with no overrun.
REQ-027 SHALL hold code, code_len and code_err stable while code_valid is 1 and the symbol is not accepted.
REQ-028 SHALL keep overrun at 1 until reset.

Reset
REQ-029 SHALL, while reset is 1 at a rising edge:
- set state to IDLE;
- clear all counters, the assembly, the synchronizer and the buffer;
- drive code, code_len, code_err, code_valid, overrun and key_db to 0.
REQ-030 SHALL abandon any partial letter and any unaccepted symbol on reset mid-operation, with no emission.
REQ-031 SHALL ignore a key held through reset release until debounce completes.

Configuration
REQ-032 SHALL, when MORSE_WORD_GAP_EN is defined, emit one space symbol (code = 0, code_len = 0, code_err = 0) through the buffer once the gap counter reaches WORD_GAP_CYCLES.
- The gap counter keeps counting in IDLE after a letter emission.
- The space is emitted at most once per release period and is re-armed only by a press.
REQ-033 SHALL, without MORSE_WORD_GAP_EN, never emit code_len = 0; the gap counter stops in IDLE and WORD_GAP_CYCLES is unused.

Verification
All scenarios use DEBOUNCE_CYCLES = 4, DOT_MAX_CYCLES = 20, GAP_CYCLES = 40, WORD_GAP_CYCLES = 100, with code_ready = 1 unless stated.
REQ-034 SHALL cover a dot: press 10 cycles, then release 60 cycles -> one code_valid pulse with code = 00000, code_len = 1.
REQ-035 SHALL cover the letter K (dash-dot-dash): press 30 cycles, 10-cycle gap, press 10 cycles, 10-cycle gap, press 30 cycles, then release -> code = 00101, code_len = 3, code_err = 0.
REQ-036 SHALL cover a long letter: 6 dots with 10-cycle gaps -> code_len = 5, code_err = 1, code = 00000.
REQ-037 SHALL cover backpressure: code_ready = 0, two letters emitted -> first letter held stable and overrun = 1; then code_ready = 1 -> first letter accepted and code_valid = 0.
REQ-038 SHALL cover a glitch: a 2-cycle pulse on morse -> key_db stays 0 and nothing is emitted.
REQ-039 SHALL cover reset mid-press: reset asserted during PRESS -> all outputs 0 and no symbol emitted; with MORSE_WORD_GAP_EN defined, 120 idle cycles after a letter -> exactly one symbol with code_len = 0.

Source files
------------

// File: rtl/morse_symbol_capture.sv
// morse_symbol_capture
//   Turns a raw Morse key into letter symbols. The key is synchronized and
//   debounced. Presses are classified as dots or dashes and packed into a
//   letter of up to five elements. A letter is emitted through a one-entry
//   output buffer once the key has been released for GAP_CYCLES.
//
// Ports
//   clock       single clock, rising edge
//   reset       synchronous, active-high reset
//   morse       raw asynchronous key input, 1 = pressed
//   code        letter elements, LSB = first element, 1 = dash, 0 = dot
//   code_len    number of elements 0..5 (0 = word space)
//   code_err    letter had more than five elements
//   code_valid  output buffer holds a symbol
//   code_ready  consumer accepts the symbol when code_valid is also 1
//   overrun     sticky, a symbol was dropped because the buffer was full
//   key_db      debounced key level
//
// Build option
//   MORSE_WORD_GAP_EN : when defined, a release lasting WORD_GAP_CYCLES
//   emits one word-space symbol (code_len = 0). Undefined by default.

module morse_symbol_capture #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DOT_MAX_CYCLES  = 10000000,
  parameter int GAP_CYCLES      = 20000000,
  parameter int WORD_GAP_CYCLES = 50000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       morse,
  output logic [4:0] code,
  output logic [2:0] code_len,
  output logic       code_err,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       overrun,
  output logic       key_db
);

  // Debounce counter only needs to reach DEBOUNCE_CYCLES-1.
  localparam int          DB_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [25:0] DOT_MAX_W = 26'(DOT_MAX_CYCLES);
  localparam logic [25:0] GAP_W     = 26'(GAP_CYCLES);
  localparam logic [25:0] WORD_GAP_W = 26'(WORD_GAP_CYCLES);
  localparam logic [25:0] CNT_MAX   = 26'h3FF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Saturating increment shared by the duration and gap counters.
  function automatic logic [25:0] sat_inc(input logic [25:0] v);
    return (v == CNT_MAX) ? v : (v + 26'd1);
  endfunction

  logic            sync1_r;
  logic            sync2_r;
  logic [DB_W-1:0] db_cnt_r;
  logic            key_db_r;
  logic            key_db_prev_r;
  logic            rise_s;
  logic            fall_s;
  logic            dash_s;

  state_t          state_r;
  logic [25:0]     dur_r;
  logic [25:0]     gap_r;
  logic [4:0]      asm_code_r;
  logic [2:0]      asm_len_r;
  logic            asm_err_r;

  logic            emit_r;
  logic [4:0]      sym_code_r;
  logic [2:0]      sym_len_r;
  logic            sym_err_r;

  logic [4:0]      code_r;
  logic [2:0]      code_len_r;
  logic            code_err_r;
  logic            code_valid_r;
  logic            overrun_r;
  logic            accept_s;

`ifdef MORSE_WORD_GAP_EN
  // Set by a press, cleared when the word space goes out: one space per release.
  logic            armed_r;
`else
  logic            unused_word_gap_s;
  assign unused_word_gap_s = ^WORD_GAP_W;
`endif

  assign rise_s   = key_db_r & ~key_db_prev_r;
  assign fall_s   = ~key_db_r & key_db_prev_r;
  assign dash_s   = (dur_r > DOT_MAX_W);
  assign accept_s = code_valid_r & code_ready;

  // Two-flop synchronizer for the asynchronous key.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= morse;
      sync2_r <= sync1_r;
    end
  end

  // Debounce: toggle after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clock) begin
    if (reset) begin
      db_cnt_r      <= '0;
      key_db_r      <= 1'b0;
      key_db_prev_r <= 1'b0;
    end else begin
      key_db_prev_r <= key_db_r;
      if (sync2_r == key_db_r) begin
        db_cnt_r <= '0;
      end else if (db_cnt_r == DB_LAST) begin
        key_db_r <= ~key_db_r;
        db_cnt_r <= '0;
      end else begin
        db_cnt_r <= db_cnt_r + DB_W'(1);
      end
    end
  end

  // Element timing, letter assembly and symbol emission.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      dur_r      <= 26'd0;
      gap_r      <= 26'd0;
      asm_code_r <= 5'd0;
      asm_len_r  <= 3'd0;
      asm_err_r  <= 1'b0;
      emit_r     <= 1'b0;
      sym_code_r <= 5'd0;
      sym_len_r  <= 3'd0;
      sym_err_r  <= 1'b0;
`ifdef MORSE_WORD_GAP_EN
      armed_r    <= 1'b0;
`endif
    end else begin
      emit_r <= 1'b0;
`ifdef MORSE_WORD_GAP_EN
      if (rise_s) begin
        armed_r <= 1'b1;
      end
`endif
      case (state_r)
        ST_IDLE: begin
          if (rise_s) begin
            state_r <= ST_PRESS;
            dur_r   <= 26'd1;
          end
`ifdef MORSE_WORD_GAP_EN
          else if (armed_r) begin
            // Gap keeps running after a letter so a word space can follow.
            if (gap_r == WORD_GAP_W) begin
              emit_r     <= 1'b1;
              sym_code_r <= 5'd0;
              sym_len_r  <= 3'd0;
              sym_err_r  <= 1'b0;
              armed_r    <= 1'b0;
            end
            gap_r <= sat_inc(gap_r);
          end
`endif
        end
        ST_PRESS: begin
          if (fall_s) begin
            if (asm_len_r < 3'd5) begin
              asm_code_r <= asm_code_r | ({4'b0000, dash_s} << asm_len_r);
              asm_len_r  <= asm_len_r + 3'd1;
            end else begin
              asm_err_r <= 1'b1;
            end
            gap_r   <= 26'd1;
            state_r <= ST_GAP;
          end else begin
            dur_r <= sat_inc(dur_r);
          end
        end
        ST_GAP: begin
          if (gap_r == GAP_W) begin
            emit_r     <= 1'b1;
            sym_code_r <= asm_code_r;
            sym_len_r  <= asm_len_r;
            sym_err_r  <= asm_err_r;
            asm_code_r <= 5'd0;
            asm_len_r  <= 3'd0;
            asm_err_r  <= 1'b0;
            // A press landing on the terminating cycle starts the next letter.
            if (rise_s) begin
              state_r <= ST_PRESS;
              dur_r   <= 26'd1;
            end else begin
              state_r <= ST_IDLE;
              gap_r   <= sat_inc(gap_r);
            end
          end else if (rise_s) begin
            state_r <= ST_PRESS;
            dur_r   <= 26'd1;
          end else begin
            gap_r <= sat_inc(gap_r);
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // One-entry output buffer; accept and reload in the same cycle is lossless.
  always_ff @(posedge clock) begin
    if (reset) begin
      code_r       <= 5'd0;
      code_len_r   <= 3'd0;
      code_err_r   <= 1'b0;
      code_valid_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else if (emit_r) begin
      if (!code_valid_r || accept_s) begin
        code_r       <= sym_code_r;
        code_len_r   <= sym_len_r;
        code_err_r   <= sym_err_r;
        code_valid_r <= 1'b1;
      end else begin
        overrun_r <= 1'b1;
      end
    end else if (accept_s) begin
      code_valid_r <= 1'b0;
    end else begin
      code_valid_r <= code_valid_r;
    end
  end

  assign code       = code_r;
  assign code_len   = code_len_r;
  assign code_err   = code_err_r;
  assign code_valid = code_valid_r;
  assign overrun    = overrun_r;
  assign key_db     = key_db_r;

endmodule

// File: tb/tb_morse_symbol_capture.sv
// Bench for morse_symbol_capture. Key timing is described as lists of
// press/release lengths; a letter-level model derives the expected symbols.

module tb_morse_symbol_capture;

  localparam int DB   = 4;
  localparam int DOT  = 20;
  localparam int GAP  = 40;
  localparam int WORD = 100;
  localparam logic [8:0] DOT_SYM = {5'b00000, 3'd1, 1'b0};

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       morse = 1'b0;
  logic       code_ready = 1'b1;
  logic [4:0] code;
  logic [2:0] code_len;
  logic       code_err;
  logic       code_valid;
  logic       overrun;
  logic       key_db;

  int total = 0;
  int bad   = 0;

  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];
  int         pr_q[$];
  int         rl_q[$];

  always #5 clock = ~clock;

  morse_symbol_capture #(
    .DEBOUNCE_CYCLES (DB),
    .DOT_MAX_CYCLES  (DOT),
    .GAP_CYCLES      (GAP),
    .WORD_GAP_CYCLES (WORD)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .morse      (morse),
    .code       (code),
    .code_len   (code_len),
    .code_err   (code_err),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .overrun    (overrun),
    .key_db     (key_db)
  );

  // Record every symbol that will be accepted at the next rising edge.
  always @(negedge clock) begin
    if (code_valid && code_ready) got_q.push_back({code, code_len, code_err});
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    morse = 1'b0;
    code_ready = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    step();
  endtask

  // Letter-level model: presses longer than DOT are dashes, a release of at
  // least GAP ends the letter, the first five elements are kept.
  function automatic void model();
    logic       el[$];
    logic [4:0] c;
    int         n;
    exp_q.delete();
    for (int i = 0; i < pr_q.size(); i++) begin
      el.push_back(pr_q[i] > DOT);
      if (rl_q[i] >= GAP) begin
        c = 5'd0;
        n = el.size();
        for (int k = 0; k < n && k < 5; k++) c[k] = el[k];
        exp_q.push_back({c, 3'(n > 5 ? 5 : n), 1'(n > 5)});
`ifdef MORSE_WORD_GAP_EN
        if (rl_q[i] >= WORD) exp_q.push_back(9'd0);
`endif
        el.delete();
      end
    end
  endfunction

  task automatic check_syms(input string tag, input int base);
    chk({tag, "_count"}, 32'(got_q.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < got_q.size()) chk({tag, "_sym"}, 32'(got_q[base + i]), 32'(exp_q[i]));
    end
  endtask

  task automatic run_seq(input string tag);
    int base;
    base = got_q.size();
    model();
    for (int i = 0; i < pr_q.size(); i++) begin
      morse = 1'b1;
      repeat (pr_q[i]) step();
      morse = 1'b0;
      repeat (rl_q[i]) step();
    end
    repeat (20) step();
    check_syms(tag, base);
  endtask

  initial begin
    int   base;
    int   ne;
    int   unstable;
    logic kdb_hi;

    // Reset values, sampled while reset is still asserted.
    repeat (2) step();
    chk("rst_code", 32'(code), 32'd0);
    chk("rst_len", 32'(code_len), 32'd0);
    chk("rst_err", 32'(code_err), 32'd0);
    chk("rst_valid", 32'(code_valid), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_key_db", 32'(key_db), 32'd0);

    // Single dot.
    do_reset();
    pr_q = '{10};
    rl_q = '{60};
    run_seq("dot");

    // K = dash dot dash.
    do_reset();
    pr_q = '{30, 10, 30};
    rl_q = '{10, 10, 60};
    run_seq("letter_k");

    // Six dots: five kept, error flagged.
    do_reset();
    pr_q = '{10, 10, 10, 10, 10, 10};
    rl_q = '{10, 10, 10, 10, 10, 60};
    run_seq("long");

    // Classification boundary: DOT cycles is a dot, DOT+1 a dash.
    do_reset();
    pr_q = '{DOT, DOT + 1};
    rl_q = '{10, 60};
    run_seq("dot_boundary");

    // Random letters.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      pr_q.delete();
      rl_q.delete();
      for (int l = 0; l < 4; l++) begin
        ne = int'($urandom_range(7, 1));
        for (int e = 0; e < ne; e++) begin
          pr_q.push_back(int'($urandom_range(35, 6)));
          if (e == ne - 1) rl_q.push_back(int'($urandom_range(70, 45)));
          else rl_q.push_back(int'($urandom_range(30, 6)));
        end
      end
      run_seq("random");
    end

    // Glitch shorter than the debounce window.
    do_reset();
    base = got_q.size();
    kdb_hi = 1'b0;
    morse = 1'b1;
    repeat (2) step();
    morse = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      kdb_hi = kdb_hi | key_db;
    end
    chk("glitch_key_db", 32'(kdb_hi), 32'd0);
    exp_q.delete();
    check_syms("glitch", base);

    // Backpressure: first letter held, second dropped.
    do_reset();
    base = got_q.size();
    code_ready = 1'b0;
    morse = 1'b1;
    repeat (10) step();
    morse = 1'b0;
    repeat (60) step();
    chk("bp_valid", 32'(code_valid), 32'd1);
    chk("bp_first", 32'({code, code_len, code_err}), 32'(DOT_SYM));
    chk("bp_overrun_early", 32'(overrun), 32'd0);
    unstable = 0;
    morse = 1'b1;
    for (int i = 0; i < 90; i++) begin
      if (i == 30) morse = 1'b0;
      step();
      if (!code_valid || {code, code_len, code_err} != DOT_SYM) unstable++;
    end
    chk("bp_hold_stable", 32'(unstable), 32'd0);
    chk("bp_overrun", 32'(overrun), 32'd1);
    code_ready = 1'b1;
    step();
    chk("bp_valid_after_accept", 32'(code_valid), 32'd0);
    exp_q.delete();
    exp_q.push_back(DOT_SYM);
    check_syms("bp", base);
    repeat (5) step();
    chk("bp_overrun_sticky", 32'(overrun), 32'd1);
    do_reset();
    chk("bp_overrun_cleared", 32'(overrun), 32'd0);

    // Reset during a press, key still held through reset release.
    do_reset();
    base = got_q.size();
    morse = 1'b1;
    repeat (15) step();
    chk("mid_key_db_before", 32'(key_db), 32'd1);
    reset = 1'b1;
    step();
    chk("mid_outputs", 32'({code, code_len, code_err, code_valid, overrun, key_db}), 32'd0);
    step();
    reset = 1'b0;
    repeat (2) step();
    chk("mid_key_db_held", 32'(key_db), 32'd0);
    morse = 1'b0;
    repeat (80) step();
    chk("mid_key_db_end", 32'(key_db), 32'd0);
    exp_q.delete();
    check_syms("mid_reset", base);

    // Long idle after a letter: a word space only when the option is built in.
    do_reset();
    pr_q = '{10};
    rl_q = '{120};
    run_seq("word_gap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
